// File: rtl/tournament_pkg.sv
// Shared widths, types and the chooser counter update rule for the tournament
// predictor chooser table controller.
package tournament_pkg;

  localparam int IDX_W = 8;
  localparam int CTR_W = 2;
  localparam logic [CTR_W-1:0] INIT_VAL = 2'b01;

  typedef logic [CTR_W-1:0] ctr_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Saturating 2-bit chooser: move toward global when only global was right,
  // toward local when only local was right, otherwise hold.
  function automatic ctr_t chooser_next(input ctr_t old, input logic local_ok,
                                        input logic global_ok);
    ctr_t nxt;
    nxt = old;
    if (global_ok && !local_ok && (old != 2'b11)) nxt = old + 2'b01;
    else if (local_ok && !global_ok && (old != 2'b00)) nxt = old - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/tournament_chooser_ctrl.sv
// Chooser table controller: init sweep of the SRAM macro, fetch lookups and
// read-modify-write counter updates with bypass of the same-edge write hazard.
module tournament_chooser_ctrl #(
  parameter int IDX_W = tournament_pkg::IDX_W,
  parameter int CTR_W = tournament_pkg::CTR_W,
  parameter logic [CTR_W-1:0] INIT_VAL = tournament_pkg::INIT_VAL
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_done,
  input  logic             lkup_valid,
  input  logic [IDX_W-1:0] lkup_idx,
  output logic             lkup_ready,
  output logic             resp_valid,
  output logic [CTR_W-1:0] resp_ctr,
  output logic             resp_use_global,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_local_ok,
  input  logic             upd_global_ok,
  output logic             upd_ready,
  output logic             sram_csb0,
  output logic [IDX_W-1:0] sram_addr0,
  output logic [CTR_W-1:0] sram_din0,
  output logic             sram_csb1,
  output logic [IDX_W-1:0] sram_addr1,
  input  logic [CTR_W-1:0] sram_dout1
);
  import tournament_pkg::*;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             init_done_q, init_done_d;
  logic             resp_valid_q, resp_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [IDX_W-1:0] s2_idx_q, s2_idx_d;
  logic             s2_local_q, s2_local_d;
  logic             s2_global_q, s2_global_d;
  logic             byp_valid_q, byp_valid_d;
  logic [IDX_W-1:0] byp_idx_q, byp_idx_d;
  logic [CTR_W-1:0] byp_data_q, byp_data_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;

  logic             lkup_fire, upd_fire, rd_en, wr_en;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [CTR_W-1:0] rd_data, wr_data, s2_new;

  always_comb begin
    lkup_fire = lkup_valid && init_done_q && !rst;
    upd_fire  = upd_valid && init_done_q && !lkup_valid && !rst;
    rd_en     = lkup_fire || upd_fire;
    rd_idx    = lkup_fire ? lkup_idx : upd_idx;

    // The macro returns pre-write data when read and write share an edge.
    rd_data = (byp_valid_q && (byp_idx_q == rd_idx_q)) ? byp_data_q : sram_dout1;
    s2_new  = chooser_next(rd_data, s2_local_q, s2_global_q);

    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = sweep_q;
      wr_data = INIT_VAL;
    end else if (s2_valid_q && (s2_new != rd_data)) begin
      wr_en   = 1'b1;
      wr_idx  = s2_idx_q;
      wr_data = s2_new;
    end
    if (rst) begin
      wr_en   = 1'b0;
      wr_idx  = '0;
      wr_data = '0;
    end

    state_d     = state_q;
    sweep_d     = sweep_q;
    init_done_d = init_done_q;
    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (&sweep_q) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end

    resp_valid_d = lkup_fire;
    s2_valid_d   = upd_fire;
    s2_idx_d     = upd_idx;
    s2_local_d   = upd_local_ok;
    s2_global_d  = upd_global_ok;
    byp_valid_d  = wr_en;
    byp_idx_d    = wr_idx;
    byp_data_d   = wr_data;
    rd_idx_d     = rd_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      init_done_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_idx_q     <= '0;
      s2_local_q   <= 1'b0;
      s2_global_q  <= 1'b0;
      byp_valid_q  <= 1'b0;
      byp_idx_q    <= '0;
      byp_data_q   <= '0;
      rd_idx_q     <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      init_done_q  <= init_done_d;
      resp_valid_q <= resp_valid_d;
      s2_valid_q   <= s2_valid_d;
      s2_idx_q     <= s2_idx_d;
      s2_local_q   <= s2_local_d;
      s2_global_q  <= s2_global_d;
      byp_valid_q  <= byp_valid_d;
      byp_idx_q    <= byp_idx_d;
      byp_data_q   <= byp_data_d;
      rd_idx_q     <= rd_idx_d;
    end
  end

  assign init_done       = init_done_q;
  assign lkup_ready      = init_done_q;
  assign upd_ready       = init_done_q && !lkup_valid;
  assign resp_valid      = resp_valid_q && !rst;
  assign resp_ctr        = resp_valid ? rd_data : '0;
  assign resp_use_global = resp_ctr[CTR_W-1];

  assign sram_csb0  = !wr_en;
  assign sram_addr0 = wr_idx;
  assign sram_din0  = wr_data;
  assign sram_csb1  = !rd_en;
  assign sram_addr1 = rd_en ? rd_idx : '0;

endmodule

// File: tb/tb_tournament_chooser_ctrl.sv
// Scoreboard bench for the chooser controller with a read-first SRAM macro model.
module tb_tournament_chooser_ctrl;

  logic       clk, rst;
  logic       init_done, lkup_valid, lkup_ready, resp_valid, resp_use_global;
  logic [7:0] lkup_idx, upd_idx, sram_addr0, sram_addr1;
  logic [1:0] resp_ctr, sram_din0, sram_dout1;
  logic       upd_valid, upd_local_ok, upd_global_ok, upd_ready;
  logic       sram_csb0, sram_csb1;

  tournament_chooser_ctrl dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .lkup_valid(lkup_valid), .lkup_idx(lkup_idx), .lkup_ready(lkup_ready),
    .resp_valid(resp_valid), .resp_ctr(resp_ctr), .resp_use_global(resp_use_global),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_local_ok(upd_local_ok),
    .upd_global_ok(upd_global_ok), .upd_ready(upd_ready),
    .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ctr;
    int due;
  } exp_t;

  int   n_checks = 0;
  int   n_fail = 0;
  int   neg_cnt = 0;
  int   sweep_seen = 0;
  int   run_writes = 0;
  int   exp_run_writes = 0;
  int   model_tbl [256];
  logic [1:0] mem [256];
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int req);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=%0d required=%0d", name, act, req);
  endtask

  // Macro: read returns the contents before any write sampled at the same edge.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 2'b10 + 2'($urandom_range(0, 1));
    forever begin
      @(posedge clk);
      if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
      if (!sram_csb0) begin
        mem[sram_addr0] <= sram_din0;
        if (rst) fail_now("write_during_reset", 1, 0);
        else if (sweep_seen < 256) begin
          check("sweep_addr", 32'(sram_addr0), 32'(sweep_seen));
          check("sweep_data", 32'(sram_din0), 32'd1);
          sweep_seen++;
        end else run_writes++;
      end
      if (rst) sweep_seen = 0;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      neg_cnt++;
      if (resp_valid) begin
        if (rst) fail_now("resp_during_reset", 1, 0);
        else if (q.size() == 0) fail_now("resp_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          check("resp_cycle", 32'(neg_cnt), 32'(e.due));
          check("resp_ctr", 32'(resp_ctr), 32'(e.ctr));
          check("resp_use_global", 32'(resp_use_global), 32'(e.ctr / 2));
        end
      end
      while (q.size() > 0 && q[0].due < neg_cnt) begin
        e = q.pop_front();
        fail_now("resp_missing", 0, 1);
      end
    end
  end

  task automatic clear_inputs();
    lkup_valid = 0; lkup_idx = 0; upd_valid = 0; upd_idx = 0;
    upd_local_ok = 0; upd_global_ok = 0;
  endtask

  task automatic step(input logic lv, input logic [7:0] li, input logic uv,
                      input logic [7:0] ui, input logic ul, input logic ug);
    exp_t e;
    int   old, nw;
    @(negedge clk);
    lkup_valid = lv; lkup_idx = li; upd_valid = uv; upd_idx = ui;
    upd_local_ok = ul; upd_global_ok = ug;
    #2;
    check("lkup_ready", 32'(lkup_ready), 32'd1);
    check("upd_ready", 32'(upd_ready), 32'(!lv));
    @(posedge clk);
    if (lv) begin
      e.ctr = model_tbl[li];
      e.due = neg_cnt + 1;
      q.push_back(e);
    end else if (uv) begin
      old = model_tbl[ui];
      nw  = old;
      if (ug && !ul) nw = (old + 1 > 3) ? 3 : old + 1;
      else if (ul && !ug) nw = (old - 1 < 0) ? 0 : old - 1;
      if (nw != old) exp_run_writes++;
      model_tbl[ui] = nw;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic lookup(input logic [7:0] idx);
    step(1, idx, 0, 0, 0, 0);
  endtask

  task automatic update(input logic [7:0] idx, input logic l, input logic g);
    step(0, 0, 1, idx, l, g);
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (init_done !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(n), 32'd256);
    for (int i = 0; i < 256; i++) model_tbl[i] = 1;
  endtask

  task automatic enter_reset(input int cycles);
    @(negedge clk);
    rst = 1;
    clear_inputs();
    repeat (cycles) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst = 1;
    clear_inputs();
    repeat (3) @(negedge clk);
    #2;
    check("rst_init_done", 32'(init_done), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_ctr", 32'(resp_ctr), 0);
    check("rst_use_global", 32'(resp_use_global), 0);
    check("rst_csb0", 32'(sram_csb0), 1);
    check("rst_csb1", 32'(sram_csb1), 1);
    check("rst_addr0", 32'(sram_addr0), 0);
    check("rst_addr1", 32'(sram_addr1), 0);
    check("rst_din0", 32'(sram_din0), 0);
    check("rst_lkup_ready", 32'(lkup_ready), 0);
    check("rst_upd_ready", 32'(upd_ready), 0);
    @(negedge clk);
    rst = 0;
    wait_init("init_latency");
    check("sweep_count", 32'(sweep_seen), 256);

    idle(2);
    lookup(0); lookup(128); lookup(255);
    idle(2);

    update(5, 0, 1); update(5, 0, 1); lookup(5);
    idle(2);
    update(5, 0, 1);
    idle(3);
    check("writes_after_saturate", 32'(run_writes), 32'(exp_run_writes));

    update(7, 0, 1); lookup(7);
    idle(2);

    step(1, 20, 1, 20, 0, 1);
    update(20, 0, 1);
    lookup(20);
    idle(2);

    update(9, 1, 0); update(9, 1, 0); update(9, 1, 0); update(9, 1, 0);
    lookup(9);
    idle(3);
    check("writes_after_underflow", 32'(run_writes), 32'(exp_run_writes));

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 3), 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 16; i++) lookup(8'(i));
    idle(3);
    check("writes_random", 32'(run_writes), 32'(exp_run_writes));
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 2'(model_tbl[i])) bad++;
    check("table_contents", 32'(bad), 0);

    // Lookup accepted, then reset lands in its response cycle.
    @(negedge clk);
    lkup_valid = 1; lkup_idx = 3;
    @(negedge clk);
    rst = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
    wait_init("init_after_resp_drop");

    // Update accepted, then reset lands in its stage-2 cycle.
    @(negedge clk);
    upd_valid = 1; upd_idx = 30; upd_global_ok = 1; upd_local_ok = 0;
    @(negedge clk);
    rst = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    #2;
    check("mid_sweep_count", 32'(sweep_seen), 100);
    check("mid_sweep_init_done", 32'(init_done), 0);
    check("mid_sweep_upd_ready", 32'(upd_ready), 0);
    enter_reset(3);
    wait_init("init_after_mid_sweep");
    check("sweep_count_restart", 32'(sweep_seen), 256);
    lookup(30); lookup(100); lookup(9);
    idle(3);
    check("writes_final", 32'(run_writes), 32'(exp_run_writes));
    check("queue_drained", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tournament_chooser_ctrl.md
# tournament_chooser_ctrl

Controller for the tournament branch predictor's chooser table: the initiator that drives the 256-entry × 2-bit `tournament_sram` macro (write port 0, read port 1). It initialises every entry after reset, answers fetch-side lookups with the stored chooser counter, and performs read-modify-write saturating updates on branch resolution, including bypass of the macro's read/write hazard. The parent instantiates the macro beside this block and ties both macro clocks to `clk`.

## Interface

- `IDX_W`, 8, table index width (256 entries)
- `CTR_W`, 2, chooser counter width (fixed to the macro word size)
- `INIT_VAL`, 2'b01, value written to every entry after reset (weakly prefer local)

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `init_done`  out  1  high once the initialisation sweep completes
- `lkup_valid`  in  1  lookup request
- `lkup_idx`  in  IDX_W  lookup index
- `lkup_ready`  out  1  equals `init_done`
- `resp_valid`  out  1  lookup response valid
- `resp_ctr`  out  CTR_W  counter value for the accepted lookup
- `resp_use_global`  out  1  `resp_ctr[1]`
- `upd_valid`  in  1  update request
- `upd_idx`  in  IDX_W  update index
- `upd_local_ok`  in  1  local predictor was correct
- `upd_global_ok`  in  1  global predictor was correct
- `upd_ready`  out  1  `init_done && !lkup_valid`
- `sram_csb0`  out  1  macro write chip select, active low
- `sram_addr0`  out  IDX_W  macro write address
- `sram_din0`  out  CTR_W  macro write data
- `sram_csb1`  out  1  macro read chip select, active low
- `sram_addr1`  out  IDX_W  macro read address
- `sram_dout1`  in  CTR_W  macro read data, valid the cycle after the read edge

## Operation

- FSM states: INIT, RUN. Reset enters INIT with sweep counter 0.
- INIT: each cycle write `INIT_VAL` to address = sweep counter (`sram_csb0`=0); counter increments; after writing address 255, move to RUN and set `init_done`. Duration: 256 cycles. Read port idle; `lkup_ready`/`upd_ready` low.
- RUN, lookup: accepted on `lkup_valid && lkup_ready`; drives `sram_csb1`=0, `sram_addr1`=`lkup_idx`. Lookup has priority over update reads.
- RUN, update stage 1: accepted on `upd_valid && upd_ready`; issues read of `upd_idx`, captures idx/ok bits into stage-2 register.
- Update stage 2 (next cycle): old value = bypassed read data; new = old+1 if global_ok && !local_ok (saturate at 3); old−1 if local_ok && !global_ok (saturate at 0); else unchanged. Write issued (`sram_csb0`=0) only when new ≠ old.
- Bypass rule: macro write lands one edge after it is issued; a read issued at the same edge as a write to the same index returns stale data. The block records {idx, data, valid} of the write issued at each edge; when the read issued at that edge matches, read data is replaced by the recorded data. Applies to both lookup responses and update stage 2.
- Back-to-back updates to the same index resolve correctly via the bypass (throughput 1/cycle).
- Idle macro ports: `sram_csb0`=`sram_csb1`=1; address/data outputs 0.

## Timing

- Reset values: `init_done`=0, `resp_valid`=0, `resp_ctr`=0, `resp_use_global`=0, `sram_csb0`=1, `sram_csb1`=1, `sram_addr0/1`=0, `sram_din0`=0; stage-2 and bypass valids cleared.
- Lookup latency: accepted at edge N → `resp_valid` high for exactly the cycle after N; `resp_ctr` combinational from `sram_dout1` or the bypass.
- Update: read at edge N, write issued at edge N+1, visible to a read issued at edge N+2 directly, or at edge N+1 via the bypass.
- `rst` mid-operation: pending response and stage 2 dropped with no write issued; INIT restarts from 0.

## Structure

- Package `tournament_pkg`: `IDX_W`, `CTR_W`, `INIT_VAL`, `ctr_t` typedef, `chooser_next(old, local_ok, global_ok)` function.
- No sub-module; single module holding INIT/RUN FSM, sweep counter, stage-2 and bypass registers.

## Test plan

- Reset, hold idle 260 cycles → `init_done` rises exactly 256 cycles after reset release; lookups of 0, 128, 255 return 2'b01.
- Update idx 5 with global_ok=1, local_ok=0, twice, then lookup 5 → `resp_ctr`=3; a third such update issues no write.
- Update idx 7 and lookup idx 7 in the cycle the update writes → response returns the new value (bypass), not the stale 1.
- Lookup and update in the same cycle → `upd_ready`=0, lookup served, update accepted the following cycle.
- Four back-to-back updates to idx 9 (local_ok=1, global_ok=0) → final value 0, saturated; no underflow.
- Assert `rst` mid-sweep at counter 100 → sweep restarts at 0; `init_done` 256 cycles after release; no response or write leaks.
